// File: rtl/fu_fifo_bank_if.sv
// Handshake/data bundle for the FU FIFO bank: per-channel config, write/read requests and status.
// Parameters must match the fu_fifo_bank instance the interface is connected to.
interface fu_fifo_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NUM_CH-1:0][1:0]              cfg_mode;
    logic [NUM_CH-1:0][AW-1:0]           cfg_delay;
    logic [NUM_CH-1:0]                   wr_en;
    logic [NUM_CH-1:0]                   rd_en;
    logic [NUM_CH-1:0][2*DATA_WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]                   err_clr;
    logic [NUM_CH-1:0][2*DATA_WIDTH-1:0] data_o;
    logic [NUM_CH-1:0]                   valid_o;
    logic [NUM_CH-1:0]                   empty_o;
    logic [NUM_CH-1:0]                   full_o;
    logic [NUM_CH-1:0]                   afull_o;
    logic [NUM_CH-1:0][CW-1:0]           count_o;
    logic [NUM_CH-1:0]                   ovf_o;
    logic [NUM_CH-1:0]                   udf_o;

    modport master (
        output cfg_mode, cfg_delay, wr_en, rd_en, data_i, err_clr,
        input  data_o, valid_o, empty_o, full_o, afull_o, count_o, ovf_o, udf_o
    );

    modport slave (
        input  cfg_mode, cfg_delay, wr_en, rd_en, data_i, err_clr,
        output data_o, valid_o, empty_o, full_o, afull_o, count_o, ovf_o, udf_o
    );
endinterface

// File: rtl/fu_fifo_bank.sv
// Bank of NUM_CH independent complex-sample FIFOs with FIFO / delay-line / flush modes and status flags.
// Optional sticky overflow/underflow flags are built when FU_FIFO_STICKY_ERR_EN is defined.
module fu_fifo_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = DEPTH - 2
) (
    input  logic           clk,
    input  logic           rst,
    fu_fifo_bank_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        ST_FIFO  = 2'd0,
        ST_DELAY = 2'd1,
        ST_FLUSH = 2'd2
    } ch_state_t;

`ifndef FU_FIFO_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = |bus.err_clr;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [EW-1:0] mem [DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0] count_reg, count_next;
            logic [1:0]    mode_reg;
            logic [AW-1:0] delay_reg;
            logic [CW-1:0] delay_eff;
            ch_state_t     st_cur;
            logic          wr_acc, rd_acc, clr;
            logic [EW-1:0] rd_data_reg, data_reg;
            logic          rd_pend_reg, valid_reg;
            logic          empty_reg, full_reg, afull_reg;

            // Registered configuration is the state: a difference from the live config forces one flush edge.
            always_ff @(posedge clk) begin
                mode_reg  <= bus.cfg_mode[gi];
                delay_reg <= bus.cfg_delay[gi];
            end

            always_comb begin
                case (bus.cfg_mode[gi])
                    2'b01:   st_cur = ST_DELAY;
                    2'b10:   st_cur = ST_FLUSH;
                    default: st_cur = ST_FIFO;
                endcase
                if (bus.cfg_mode[gi] != mode_reg)
                    st_cur = ST_FLUSH;
                if (st_cur == ST_DELAY && bus.cfg_delay[gi] != delay_reg)
                    st_cur = ST_FLUSH;
            end

            assign delay_eff = (bus.cfg_delay[gi] == '0) ? ONE_C : {1'b0, bus.cfg_delay[gi]};

            always_comb begin
                wr_acc = 1'b0;
                rd_acc = 1'b0;
                clr    = 1'b0;
                case (st_cur)
                    ST_FIFO: begin
                        rd_acc = bus.rd_en[gi] && (count_reg != '0);
                        wr_acc = bus.wr_en[gi] && ((count_reg != DEPTH_C) || rd_acc);
                    end
                    ST_DELAY: begin
                        wr_acc = 1'b1;
                        rd_acc = (count_reg == delay_eff);
                    end
                    default: clr = 1'b1;
                endcase
            end

            assign count_next = clr ? '0 : (count_reg + CW'(wr_acc) - CW'(rd_acc));

            // Read-first block RAM: a same-edge write to the head slot (full rd+wr) returns the old entry.
            always_ff @(posedge clk) begin
                if (wr_acc)
                    mem[wr_ptr_reg] <= bus.data_i[gi];
                if (rd_acc)
                    rd_data_reg <= mem[rd_ptr_reg];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg  <= '0;
                    rd_ptr_reg  <= '0;
                    count_reg   <= '0;
                    rd_pend_reg <= 1'b0;
                    valid_reg   <= 1'b0;
                    data_reg    <= '0;
                    empty_reg   <= 1'b1;
                    full_reg    <= 1'b0;
                    afull_reg   <= 1'b0;
                end else begin
                    if (clr) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                    end else begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(wr_acc);
                        rd_ptr_reg <= rd_ptr_reg + AW'(rd_acc);
                    end
                    count_reg   <= count_next;
                    rd_pend_reg <= rd_acc;
                    valid_reg   <= rd_pend_reg && !clr;
                    if (rd_pend_reg && !clr)
                        data_reg <= rd_data_reg;
                    empty_reg   <= (count_next == '0);
                    full_reg    <= (count_next == DEPTH_C);
                    afull_reg   <= (count_next >= AFULL_C);
                end
            end

            assign bus.data_o[gi]  = data_reg;
            assign bus.valid_o[gi] = valid_reg;
            assign bus.empty_o[gi] = empty_reg;
            assign bus.full_o[gi]  = full_reg;
            assign bus.afull_o[gi] = afull_reg;
            assign bus.count_o[gi] = count_reg;

`ifdef FU_FIFO_STICKY_ERR_EN
            logic ovf_reg, udf_reg;

            always_ff @(posedge clk) begin
                if (rst || bus.err_clr[gi]) begin
                    ovf_reg <= 1'b0;
                    udf_reg <= 1'b0;
                end else if (st_cur == ST_FIFO) begin
                    if (bus.wr_en[gi] && count_reg == DEPTH_C && !rd_acc)
                        ovf_reg <= 1'b1;
                    if (bus.rd_en[gi] && count_reg == '0)
                        udf_reg <= 1'b1;
                end
            end

            assign bus.ovf_o[gi] = ovf_reg;
            assign bus.udf_o[gi] = udf_reg;
`else
            assign bus.ovf_o[gi] = 1'b0;
            assign bus.udf_o[gi] = 1'b0;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_fu_fifo_bank.sv
// Self-checking bench for fu_fifo_bank: table-driven fill/drain, directed corner sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_fu_fifo_bank;
    localparam int DW    = 16;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int AFULL = 14;
`ifdef FU_FIFO_STICKY_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fu_fifo_bank_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH)) bus ();

    fu_fifo_bank #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .AFULL_TH(AFULL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per channel plus a one-deep read pipeline.
    typedef logic [31:0] word_q_t[$];
    word_q_t     mq [NCH];
    logic [1:0]  m_prev_mode [NCH];
    logic [3:0]  m_prev_delay[NCH];
    logic        m_pend_v [NCH];
    logic [31:0] m_pend_d [NCH];
    logic        m_out_v  [NCH];
    logic [31:0] m_out_d  [NCH];
    logic        m_ovf    [NCH];
    logic        m_udf    [NCH];

    task automatic check(string name, int c, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, c, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            logic [1:0]  mode;
            logic [3:0]  d;
            int          deff;
            bit          flush, rd_ok, wr_ok;
            logic [31:0] popped;
            mode   = bus.cfg_mode[c];
            d      = bus.cfg_delay[c];
            rd_ok  = 1'b0;
            wr_ok  = 1'b0;
            popped = '0;
            if (rst) begin
                mq[c].delete();
                m_pend_v[c] = 1'b0;
                m_out_v[c]  = 1'b0;
                m_out_d[c]  = '0;
                m_ovf[c]    = 1'b0;
                m_udf[c]    = 1'b0;
            end else begin
                flush = (mode == 2'b10) || (mode != m_prev_mode[c]) ||
                        (mode == 2'b01 && d != m_prev_delay[c]);
                m_out_v[c] = m_pend_v[c] && !flush;
                if (m_out_v[c])
                    m_out_d[c] = m_pend_d[c];
                if (flush) begin
                    mq[c].delete();
                end else if (mode == 2'b01) begin
                    deff = (d == 0) ? 1 : int'(d);
                    if (mq[c].size() == deff) begin
                        rd_ok  = 1'b1;
                        popped = mq[c].pop_front();
                    end
                    mq[c].push_back(bus.data_i[c]);
                end else begin
                    rd_ok = bus.rd_en[c] && (mq[c].size() > 0);
                    wr_ok = bus.wr_en[c] && ((mq[c].size() < DEPTH) || rd_ok);
                    if (ERR_EN && bus.wr_en[c] && mq[c].size() == DEPTH && !rd_ok)
                        m_ovf[c] = 1'b1;
                    if (ERR_EN && bus.rd_en[c] && mq[c].size() == 0)
                        m_udf[c] = 1'b1;
                    if (rd_ok)
                        popped = mq[c].pop_front();
                    if (wr_ok)
                        mq[c].push_back(bus.data_i[c]);
                end
                if (bus.err_clr[c]) begin
                    m_ovf[c] = 1'b0;
                    m_udf[c] = 1'b0;
                end
                m_pend_v[c] = rd_ok;
                m_pend_d[c] = popped;
            end
            m_prev_mode[c]  = mode;
            m_prev_delay[c] = d;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            int n;
            n = mq[c].size();
            check("data",  c, bus.data_o[c], m_out_d[c]);
            check("valid", c, 32'(bus.valid_o[c]), 32'(m_out_v[c]));
            check("count", c, 32'(bus.count_o[c]), 32'(n));
            check("empty", c, 32'(bus.empty_o[c]), 32'(n == 0));
            check("full",  c, 32'(bus.full_o[c]),  32'(n == DEPTH));
            check("afull", c, 32'(bus.afull_o[c]), 32'(n >= AFULL));
            check("ovf",   c, 32'(bus.ovf_o[c]),   32'(m_ovf[c]));
            check("udf",   c, 32'(bus.udf_o[c]),   32'(m_udf[c]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.wr_en   = '0;
        bus.rd_en   = '0;
        bus.err_clr = '0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [4:0]  exp_count;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_full;
        logic        exp_afull;
        logic        exp_empty;
    } vec_t;

    initial begin
        vec_t        vecs [34];
        logic [31:0] got [$];
        int          phase;

        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 1'b0, 32'h0001_0000 + 32'(i), 5'(i + 1), 1'b0, 32'h0,
                        (i == 15), ((i + 1) >= AFULL), 1'b0};
        for (int k = 0; k < 16; k++)
            vecs[16 + k] = '{1'b0, 1'b1, 32'h0, 5'(15 - k), (k >= 1),
                             (k >= 1) ? 32'h0001_0000 + 32'(k - 1) : 32'h0,
                             1'b0, ((15 - k) >= AFULL), (k == 15)};
        vecs[32] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0001_000F, 1'b0, 1'b0, 1'b1};
        vecs[33] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0001_000F, 1'b0, 1'b0, 1'b1};

        // Reset
        rst           = 1'b1;
        bus.cfg_mode  = '0;
        bus.cfg_delay = '0;
        bus.data_i    = '0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        check("rst_data",  0, bus.data_o[0], 32'h0);
        check("rst_valid", 0, 32'(bus.valid_o[0]), 32'h0);
        check("rst_empty", 0, 32'(bus.empty_o[0]), 32'h1);
        check("rst_count", 1, 32'(bus.count_o[1]), 32'h0);

        // Table-driven fill and drain on channel 0
        for (int v = 0; v < 34; v++) begin
            bus.wr_en[0]  = vecs[v].wr;
            bus.rd_en[0]  = vecs[v].rd;
            bus.data_i[0] = vecs[v].din;
            step();
            check("tbl_count", 0, 32'(bus.count_o[0]), 32'(vecs[v].exp_count));
            check("tbl_valid", 0, 32'(bus.valid_o[0]), 32'(vecs[v].exp_valid));
            check("tbl_data",  0, bus.data_o[0], vecs[v].exp_data);
            check("tbl_full",  0, 32'(bus.full_o[0]),  32'(vecs[v].exp_full));
            check("tbl_afull", 0, 32'(bus.afull_o[0]), 32'(vecs[v].exp_afull));
            check("tbl_empty", 0, 32'(bus.empty_o[0]), 32'(vecs[v].exp_empty));
        end
        idle_inputs();

        // Full with simultaneous read+write, then overflow and wrap-around drain
        for (int i = 0; i < 16; i++) begin
            bus.wr_en[0]  = 1'b1;
            bus.data_i[0] = 32'h0001_0000 + 32'(i);
            step();
        end
        bus.rd_en[0]  = 1'b1;
        bus.data_i[0] = 32'hBEEF_0001;
        step();
        check("rdwr_full_count", 0, 32'(bus.count_o[0]), 32'd16);
        idle_inputs();
        step();
        check("rdwr_head_valid", 0, 32'(bus.valid_o[0]), 32'h1);
        check("rdwr_head_data",  0, bus.data_o[0], 32'h0001_0000);
        bus.wr_en[0]  = 1'b1;
        bus.data_i[0] = 32'hDEAD_0000;
        step();
        check("ovf_set",  0, 32'(bus.ovf_o[0]), 32'(ERR_EN));
        check("ovf_count", 0, 32'(bus.count_o[0]), 32'd16);
        idle_inputs();
        for (int i = 0; i < 18; i++) begin
            bus.rd_en[0] = (i < 16);
            step();
            if (bus.valid_o[0])
                got.push_back(bus.data_o[0]);
        end
        check("drain_len", 0, 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check("drain_order", 0, got[i], (i < 15) ? 32'h0001_0001 + 32'(i) : 32'hBEEF_0001);
        check("ovf_held", 0, 32'(bus.ovf_o[0]), 32'(ERR_EN));
        idle_inputs();
        bus.rd_en[0] = 1'b1;
        step();
        check("udf_set", 0, 32'(bus.udf_o[0]), 32'(ERR_EN));
        idle_inputs();
        bus.err_clr[0] = 1'b1;
        step();
        check("clr_ovf", 0, 32'(bus.ovf_o[0]), 32'h0);
        check("clr_udf", 0, 32'(bus.udf_o[0]), 32'h0);
        idle_inputs();

        // Delay line D=5 on channel 1: first edge after the switch flushes, ramp starts next edge
        bus.cfg_delay[1] = 4'd5;
        bus.cfg_mode[1]  = 2'b01;
        step();
        check("dly_flush_count", 1, 32'(bus.count_o[1]), 32'h0);
        for (int e = 0; e < 40; e++) begin
            bus.data_i[1] = 32'(e);
            step();
            check("dly_valid", 1, 32'(bus.valid_o[1]), 32'(e >= 6));
            if (e >= 6)
                check("dly_data", 1, bus.data_o[1], 32'(e - 6));
            check("dly_count", 1, 32'(bus.count_o[1]), 32'((e + 1 < 5) ? e + 1 : 5));
        end
        bus.cfg_mode[1] = 2'b00;
        step();

        // FIFO with 7 entries switched to DELAY, then reset mid-burst
        for (int i = 0; i < 7; i++) begin
            bus.wr_en[0]  = 1'b1;
            bus.data_i[0] = 32'h0002_0000 + 32'(i);
            step();
        end
        idle_inputs();
        check("sw_pre_count", 0, 32'(bus.count_o[0]), 32'd7);
        bus.cfg_delay[0] = 4'd3;
        bus.cfg_mode[0]  = 2'b01;
        step();
        check("sw_count", 0, 32'(bus.count_o[0]), 32'h0);
        check("sw_valid", 0, 32'(bus.valid_o[0]), 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus.data_i[0] = 32'h0003_0000 + 32'(i);
            step();
        end
        rst = 1'b1;
        step();
        check("mrst_count", 0, 32'(bus.count_o[0]), 32'h0);
        check("mrst_valid", 0, 32'(bus.valid_o[0]), 32'h0);
        check("mrst_data",  0, bus.data_o[0], 32'h0);
        bus.cfg_mode = '0;
        step();
        rst = 1'b0;

        // Read in flight when reset hits
        for (int i = 0; i < 3; i++) begin
            bus.wr_en[0]  = 1'b1;
            bus.data_i[0] = 32'h0004_0000 + 32'(i);
            step();
        end
        idle_inputs();
        bus.rd_en[0] = 1'b1;
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        check("inflight_valid_rst", 0, 32'(bus.valid_o[0]), 32'h0);
        rst = 1'b0;
        step();
        check("inflight_valid_after", 0, 32'(bus.valid_o[0]), 32'h0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            phase = (cyc / 64) % 2;
            rst   = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NCH; c++) begin
                logic [1:0] old_mode;
                int         r;
                old_mode = bus.cfg_mode[c];
                if ($urandom_range(0, 39) == 0) begin
                    r = int'($urandom_range(0, 9));
                    bus.cfg_mode[c] = (r <= 5) ? 2'b00 : (r <= 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
                    if (bus.cfg_mode[c] == 2'b01 && old_mode == 2'b01)
                        bus.cfg_delay[c] = 4'($urandom_range(2, 15));
                    else
                        bus.cfg_delay[c] = 4'($urandom_range(0, 15));
                end
                if (rst)
                    bus.cfg_mode[c] = 2'b00;
                bus.wr_en[c]   = ($urandom_range(0, 99) < ((phase == 0) ? 65 : 35));
                bus.rd_en[c]   = ($urandom_range(0, 99) < ((phase == 0) ? 35 : 65));
                bus.data_i[c]  = $urandom;
                bus.err_clr[c] = ($urandom_range(0, 29) == 0) && (bus.cfg_mode[c] == old_mode) &&
                                 (old_mode == 2'b00 || old_mode == 2'b11);
            end
            step();
        end
        rst = 1'b0;
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
